imem_loader: RTL and testbench

- Write-side counterpart of the fetch path. The fetch stage reads instruction words from imem; this block writes them.
- Accepts a byte stream over a valid/ready handshake and packs bytes little-endian into XLEN-bit words.
- Issues one-cycle write strobes into the imem write port at consecutive word addresses.
- Holds the core (cpu_hold) while a program load is in progress.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/imem_loader_byte_packer.sv | 42 ++++
 rtl/imem_loader.sv | 141 ++++++++++++++
 tb/tb_imem_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the instruction-memory load path.
// Holds the loader FSM state type and byte/word sizing helpers.
package pipeline_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      WRITE,
      DONE
   } loader_state_t;

   localparam int unsigned DEFAULT_XLEN   = 32;
   localparam int unsigned BYTES_PER_WORD = DEFAULT_XLEN / 8;

   // Width of a byte index; a single-byte word still needs one bit.
   function automatic int unsigned idx_width(input int unsigned bpw);
      return (bpw > 1) ? $clog2(bpw) : 1;
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
// o_word_full flags the byte that completes the current word.
module byte_packer
   import pipeline_pkg::*;
#(
   parameter int unsigned BPW = BYTES_PER_WORD
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_load,
   input  logic               i_clear,
   input  logic [7:0]         i_byte,
   output logic [8*BPW-1:0]   o_word,
   output logic               o_word_full
);

   localparam int unsigned       IW   = idx_width(BPW);
   localparam logic [IW-1:0]     LAST = IW'(BPW - 1);

   logic [IW-1:0]     r_idx;
   logic [8*BPW-1:0]  r_word;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx  <= '0;
         r_word <= '0;
      end else if (i_clear) begin
         r_idx <= '0;
      end else if (i_load) begin
         for (int unsigned k = 0; k < BPW; k++) begin
            if (r_idx == IW'(k)) begin
               r_word[8*k +: 8] <= i_byte;
            end
         end
         r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
      end
   end

   assign o_word      = r_word;
   assign o_word_full = i_load && (r_idx == LAST);

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into imem as packed words at consecutive addresses,
// holding the core while a load is in progress and keeping a running checksum.
module imem_loader
   import pipeline_pkg::*;
#(
   parameter int unsigned XLEN       = DEFAULT_XLEN,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   load_words,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [XLEN-1:0]       wdata,
   output logic                  busy,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  overflow,
   output logic [XLEN-1:0]       checksum
);

   localparam int unsigned         BPW   = XLEN / 8;
   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   loader_state_t           r_state;
   loader_state_t           w_next;
   logic [ADDR_WIDTH:0]     r_target;
   logic [ADDR_WIDTH-1:0]   r_count;
   logic [ADDR_WIDTH-1:0]   r_waddr;
   logic [XLEN-1:0]         r_checksum;
   logic                    r_overflow;

   logic                    w_idle;
   logic                    w_start;
   logic                    w_accept;
   logic                    w_clear;
   logic                    w_word_full;
   logic                    w_last_word;
   logic [XLEN-1:0]         w_word;
   logic [ADDR_WIDTH:0]     w_target;

   assign w_idle      = (r_state == IDLE) || (r_state == DONE);
   assign w_start     = start && w_idle;
   assign w_accept    = byte_valid && (r_state == COLLECT);
   assign w_clear     = w_start || (r_state == WRITE);
   assign w_target    = (load_words > DEPTH) ? DEPTH : load_words;
   // Completion is decided by the word counter alone, so waddr never wraps.
   assign w_last_word = ({1'b0, r_count} == (r_target - 1'b1));

   byte_packer #(
      .BPW (BPW)
   ) u_packer (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_accept),
      .i_clear     (w_clear),
      .i_byte      (byte_data),
      .o_word      (w_word),
      .o_word_full (w_word_full)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_next = (w_target == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            if (w_word_full) begin
               w_next = WRITE;
            end
         end
         WRITE: begin
            w_next = w_last_word ? DONE : COLLECT;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_target   <= '0;
         r_count    <= '0;
         r_waddr    <= '0;
         r_checksum <= '0;
         r_overflow <= 1'b0;
      end else if (w_start) begin
         r_target   <= w_target;
         r_overflow <= (load_words > DEPTH);
         r_count    <= '0;
         r_waddr    <= '0;
         r_checksum <= '0;
      end else if (r_state == WRITE) begin
         r_checksum <= r_checksum + w_word;
         if (!w_last_word) begin
            r_count <= r_count + 1'b1;
            r_waddr <= r_waddr + 1'b1;
         end
      end
   end

   always_comb begin
      byte_ready = 1'b0;
      we         = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (r_state)
         COLLECT: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
         end
         WRITE: begin
            we   = 1'b1;
            busy = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   assign cpu_hold = busy;
   assign waddr    = r_waddr;
   assign wdata    = w_word;
   assign checksum = r_checksum;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a stream-level model of expected writes
// and checksum, checked every cycle by a single compare process.
module tb_imem_loader;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned AW    = 2;
   localparam int unsigned DEPTH = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [AW:0]     load_words;
   logic            byte_valid;
   logic [7:0]      byte_data;
   logic            byte_ready;
   logic            we;
   logic [AW-1:0]   waddr;
   logic [XLEN-1:0] wdata;
   logic            busy;
   logic            cpu_hold;
   logic            done;
   logic            overflow;
   logic [XLEN-1:0] checksum;

   typedef struct {
      int unsigned     addr;
      logic [XLEN-1:0] data;
   } wr_t;

   wr_t             exp_q[$];
   logic [XLEN-1:0] model_sum = '0;
   int unsigned     n_we  = 0;
   int unsigned     n_acc = 0;
   int              errors = 0;
   int              checks = 0;

   imem_loader #(
      .XLEN       (XLEN),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .load_words (load_words),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .busy       (busy),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .overflow   (overflow),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Expected writes for a load: little-endian words from the stream, clamped to depth.
   function automatic void plan(input logic [7:0] s[$], input int unsigned n);
      int unsigned target;
      target = (n > DEPTH) ? DEPTH : n;
      for (int unsigned i = 0; i < target; i++) begin
         if (4*i + 3 < s.size()) begin
            exp_q.push_back('{addr: i, data: {s[4*i+3], s[4*i+2], s[4*i+1], s[4*i]}});
         end
      end
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         check("cpu_hold_eq_busy", 64'(cpu_hold), 64'(busy));
         check("checksum_running", 64'(checksum), 64'(model_sum));
         if (byte_valid && byte_ready) n_acc++;
         if (we) begin
            n_we++;
            check("ready_low_in_write", 64'(byte_ready), 64'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_write", 64'(we), 64'd0);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("waddr", 64'(waddr), 64'(e.addr));
               check("wdata", 64'(wdata), 64'(e.data));
               model_sum = model_sum + e.data;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input int unsigned n);
      start      = 1'b1;
      load_words = (AW+1)'(n);
      tick();
      start     = 1'b0;
      model_sum = '0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      bit acc;
      acc        = 1'b0;
      byte_valid = 1'b1;
      byte_data  = b;
      for (int k = 0; k < 200 && !acc; k++) begin
         if (byte_ready) acc = 1'b1;
         tick();
      end
      if (!acc) check("byte_accept_timeout", 64'd0, 64'd1);
      byte_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic wait_done();
      for (int k = 0; k < 100 && !done; k++) tick();
      check("done_reached", 64'(done), 64'd1);
   endtask

   initial begin
      logic [7:0] s1[$];
      logic [7:0] s2[$];
      logic [7:0] s3[$];
      int unsigned we0;
      int unsigned acc0;

      reset      = 1'b1;
      start      = 1'b0;
      load_words = '0;
      byte_valid = 1'b0;
      byte_data  = '0;
      repeat (2) tick();
      reset = 1'b0;
      tick();

      check("rst_ctrl", 64'({byte_ready, we, busy, cpu_hold, done, overflow}), 64'd0);
      check("rst_waddr", 64'(waddr), 64'd0);
      check("rst_wdata", 64'(wdata), 64'd0);
      check("rst_checksum", 64'(checksum), 64'd0);

      // Basic back-to-back load of two words.
      s1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      plan(s1, 2);
      we0 = n_we;
      start_load(2);
      for (int i = 0; i < 8; i++) begin
         send_byte(s1[i], 0);
         if (i == 3) check("we_latency", 64'(we), 64'd1);
      end
      wait_done();
      check("basic_checksum", 64'(checksum), 64'h001000A6);
      check("basic_cpu_hold", 64'(cpu_hold), 64'd0);
      check("basic_writes", 64'(n_we - we0), 64'd2);
      check("basic_pending", 64'(exp_q.size()), 64'd0);

      // Same stream with three idle cycles between bytes.
      plan(s1, 2);
      we0 = n_we;
      start_load(2);
      for (int i = 0; i < 8; i++) send_byte(s1[i], 3);
      wait_done();
      check("stall_checksum", 64'(checksum), 64'h001000A6);
      check("stall_writes", 64'(n_we - we0), 64'd2);
      check("stall_pending", 64'(exp_q.size()), 64'd0);

      // Zero-length load.
      we0  = n_we;
      acc0 = n_acc;
      start_load(0);
      check("zero_done", 64'(done), 64'd1);
      check("zero_ready", 64'(byte_ready), 64'd0);
      byte_valid = 1'b1;
      byte_data  = 8'hAA;
      repeat (5) tick();
      byte_valid = 1'b0;
      check("zero_consumed", 64'(n_acc - acc0), 64'd0);
      check("zero_writes", 64'(n_we - we0), 64'd0);
      check("zero_checksum", 64'(checksum), 64'd0);

      // Overflow: six words requested against a four-word memory.
      s2 = {};
      for (int i = 0; i < 24; i++) s2.push_back(8'(i*17 + 1));
      plan(s2, 6);
      we0  = n_we;
      acc0 = n_acc;
      start_load(6);
      check("ovf_flag", 64'(overflow), 64'd1);
      for (int i = 0; i < 16; i++) send_byte(s2[i], 0);
      check("ovf_ready_drop", 64'(byte_ready), 64'd0);
      byte_valid = 1'b1;
      byte_data  = s2[16];
      repeat (8) tick();
      byte_valid = 1'b0;
      check("ovf_done", 64'(done), 64'd1);
      check("ovf_consumed", 64'(n_acc - acc0), 64'd16);
      check("ovf_writes", 64'(n_we - we0), 64'd4);
      check("ovf_last_waddr", 64'(waddr), 64'd3);
      check("ovf_checksum", 64'(checksum), 64'h6A25E19C);
      check("ovf_pending", 64'(exp_q.size()), 64'd0);

      // Reset during the second word of a three-word load.
      s3 = '{8'h37, 8'h05, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44};
      plan(s3, 1);
      we0 = n_we;
      start_load(3);
      for (int i = 0; i < 6; i++) send_byte(s3[i], 0);
      check("mid_busy", 64'(busy), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("arst_ctrl", 64'({byte_ready, we, busy, cpu_hold, done, overflow}), 64'd0);
      check("arst_waddr", 64'(waddr), 64'd0);
      check("arst_wdata", 64'(wdata), 64'd0);
      check("arst_checksum", 64'(checksum), 64'd0);
      model_sum = '0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      check("arst_writes", 64'(n_we - we0), 64'd1);
      s1 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      plan(s1, 1);
      we0 = n_we;
      start_load(1);
      for (int i = 0; i < 4; i++) send_byte(s1[i], 1);
      wait_done();
      check("after_rst_writes", 64'(n_we - we0), 64'd1);
      check("after_rst_checksum", 64'(checksum), 64'hDEADBEEF);
      check("after_rst_pending", 64'(exp_q.size()), 64'd0);

      // Start pulse during COLLECT must be ignored.
      s1 = '{8'h01, 8'h02, 8'h03, 8'h04};
      plan(s1, 1);
      we0 = n_we;
      start_load(1);
      send_byte(s1[0], 0);
      send_byte(s1[1], 0);
      start      = 1'b1;
      load_words = (AW+1)'(5);
      tick();
      start = 1'b0;
      send_byte(s1[2], 0);
      send_byte(s1[3], 0);
      wait_done();
      acc0 = n_acc;
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      repeat (5) tick();
      byte_valid = 1'b0;
      check("ign_writes", 64'(n_we - we0), 64'd1);
      check("ign_done", 64'(done), 64'd1);
      check("ign_overflow", 64'(overflow), 64'd0);
      check("ign_consumed", 64'(n_acc - acc0), 64'd0);
      check("ign_checksum", 64'(checksum), 64'h04030201);
      check("ign_pending", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
